// File: rtl/moller_stream_pkg.sv
// Shared definitions for the packet arbiter.
// Contents:
//   state_t       - arbiter FSM states
//   HDR_*         - bit positions of the header word fields
//   build_header  - assembles the 64-bit header word from its fields
package moller_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DISCARD,
        ST_HDR,
        ST_DRAIN
    } state_t;

    localparam int unsigned HDR_ID_LSB    = 56;
    localparam int unsigned HDR_SRC_LSB   = 48;
    localparam int unsigned HDR_TRUNC_BIT = 32;
    localparam int unsigned HDR_SEQ_LSB   = 16;
    localparam int unsigned HDR_LEN_LSB   = 0;

    // Header layout: [63:56] id, [55:48] src, [47:33] zero, [32] trunc,
    // [31:16] seq, [15:0] len.
    function automatic logic [63:0] build_header(input logic [7:0]  id,
                                                 input logic [7:0]  src,
                                                 input logic        trunc,
                                                 input logic [15:0] seq,
                                                 input logic [15:0] len);
        logic [63:0] h;
        h                       = '0;
        h[HDR_ID_LSB  +: 8]     = id;
        h[HDR_SRC_LSB +: 8]     = src;
        h[HDR_TRUNC_BIT]        = trunc;
        h[HDR_SEQ_LSB +: 16]    = seq;
        h[HDR_LEN_LSB +: 16]    = len;
        return h;
    endfunction

endpackage

// File: rtl/pkt_buffer_sdp.sv
// Simple dual-port payload buffer, 2**DEPTH_BITS x DATA_WIDTH.
// Ports:
//   clk_i      - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_en_i    - read strobe; rd_data_o only changes when this is high
//   rd_addr_i  - read address
//   rd_data_o  - registered read data (one cycle after rd_en_i)
module pkt_buffer_sdp #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_BITS-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_BITS-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_BITS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        // Read data is held while rd_en_i is low so the output word stays
        // stable under downstream backpressure.
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_stream_pkt_arbiter.sv
// Store-and-forward AXI-stream merger. Each granted source packet is
// buffered whole, then sent as one header word followed by the payload.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   ena                            - allows new grants (packet in flight completes)
//   in_tdata/in_tvalid/in_tlast    - NUM_SRC packed input streams
//   in_tready                      - per-source ready, one-hot or zero
//   out_tdata/out_tvalid/out_tlast - merged output stream
//   out_tready                     - downstream ready
//   pkt_count                      - packets emitted (wraps)
//   trunc_count                    - truncated packets (saturates)
//   busy                           - FSM not idle
module axi_stream_pkt_arbiter
    import moller_stream_pkg::*;
#(
    parameter int         NUM_SRC     = 3,
    parameter int         DATA_WIDTH  = 64,
    parameter int         DEPTH_BITS  = 8,
    parameter int         MAX_PKT_LEN = 64,
    parameter logic [7:0] ID_BASE     = 8'hF0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_tdata,
    input  logic [NUM_SRC-1:0]            in_tvalid,
    input  logic [NUM_SRC-1:0]            in_tlast,
    output logic [NUM_SRC-1:0]            in_tready,
    output logic [DATA_WIDTH-1:0]         out_tdata,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    input  logic                          out_tready,
    output logic [31:0]                   pkt_count,
    output logic [15:0]                   trunc_count,
    output logic                          busy
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT_LEN);

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;
    logic               trunc_q, trunc_d;
    logic [15:0]        seq_q, seq_d;
    logic [31:0]        pkt_cnt_q, pkt_cnt_d;
    logic [15:0]        trunc_cnt_q, trunc_cnt_d;

    logic [SRC_W-1:0]      pick;
    logic                  pick_vld;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_last;
    logic                  beat;
    logic                  last_word;
    logic                  wr_en;
    logic                  rd_en;
    logic [DEPTH_BITS-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin search: first valid source starting at rr+1, wrapping.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        cand     = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            cand = SRC_W'(idx);
            if (!pick_vld && in_tvalid[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        src_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant_q == SRC_W'(s)) begin
                src_data = in_tdata[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign src_last  = in_tlast[grant_q];
    assign beat      = |(in_tvalid & in_tready);
    assign last_word = (rd_idx_q == len_q - 1'b1);

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            seq_q       <= '0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            seq_q       <= seq_d;
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    // Per-packet registers; always loaded before use, so no reset needed
    always_ff @(posedge clk) begin
        grant_q  <= grant_d;
        count_q  <= count_d;
        len_q    <= len_d;
        trunc_q  <= trunc_d;
        rd_idx_q <= rd_idx_d;
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        count_d     = count_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        rd_idx_d    = rd_idx_q;
        seq_d       = seq_q;
        pkt_cnt_d   = pkt_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ena && pick_vld) begin
                    grant_d = pick;
                    rr_d    = pick;
                    count_d = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (beat) begin
                    if (src_last) begin
                        len_d   = count_q + 1'b1;
                        trunc_d = 1'b0;
                        state_d = ST_HDR;
                    end else if (count_q + 1'b1 == MAX_LEN) begin
                        len_d   = MAX_LEN;
                        trunc_d = 1'b1;
                        state_d = ST_DISCARD;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (beat && src_last) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                rd_idx_d = '0;
                if (out_tready) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_tready) begin
                    if (last_word) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        if (trunc_q) begin
                            trunc_cnt_d = sat_inc16(trunc_cnt_q);
                        end
                        state_d = ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_tready  = '0;
        out_tdata  = '0;
        out_tvalid = 1'b0;
        out_tlast  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        unique case (state_q)
            ST_FILL: begin
                in_tready[grant_q] = 1'b1;
                wr_en              = in_tvalid[grant_q];
            end
            ST_DISCARD: begin
                in_tready[grant_q] = 1'b1;
            end
            ST_HDR: begin
                out_tvalid = 1'b1;
                out_tdata  = build_header(ID_BASE + 8'(grant_q), 8'(grant_q),
                                          trunc_q, seq_q, 16'(len_q));
                // Prefetch word 0 so the first payload word follows the
                // header without a bubble.
                rd_en      = 1'b1;
                rd_addr    = '0;
            end
            ST_DRAIN: begin
                out_tvalid = 1'b1;
                out_tdata  = rd_data;
                out_tlast  = last_word;
                if (out_tready && !last_word) begin
                    rd_en   = 1'b1;
                    rd_addr = DEPTH_BITS'(rd_idx_q + 1'b1);
                end
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign pkt_count   = pkt_cnt_q;
    assign trunc_count = trunc_cnt_q;

    pkt_buffer_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_buf (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (DEPTH_BITS'(count_q)),
        .wr_data_i (src_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// Bench for axi_stream_pkt_arbiter: reset state, a table of single-packet
// vectors, hand-written ena / mid-packet reset sequences, and a randomized
// multi-source run checked against a round-robin stream model.
module tb_axi_stream_pkt_arbiter;

    localparam int NSRC = 3;
    localparam int DW   = 64;
    localparam int MAXL = 64;

    logic                 clk;
    logic                 rst;
    logic                 ena;
    logic [NSRC*DW-1:0]   in_tdata;
    logic [NSRC-1:0]      in_tvalid;
    logic [NSRC-1:0]      in_tlast;
    logic [NSRC-1:0]      in_tready;
    logic [DW-1:0]        out_tdata;
    logic                 out_tvalid;
    logic                 out_tlast;
    logic                 out_tready;
    logic [31:0]          pkt_count;
    logic [15:0]          trunc_count;
    logic                 busy;

    axi_stream_pkt_arbiter #(
        .NUM_SRC     (NSRC),
        .DATA_WIDTH  (DW),
        .DEPTH_BITS  (8),
        .MAX_PKT_LEN (MAXL),
        .ID_BASE     (8'hF0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tlast    (in_tlast),
        .in_tready   (in_tready),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tlast   (out_tlast),
        .out_tready  (out_tready),
        .pkt_count   (pkt_count),
        .trunc_count (trunc_count),
        .busy        (busy)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        int          src;
        int          nw;
        logic [63:0] base;
        bit          rnd;
        logic [63:0] hdr;
        logic [31:0] pkts;
        logic [15:0] truncs;
    } vec_t;

    beat_t srcq [NSRC][$];
    beat_t obeats[$];
    beat_t expq[$];

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  acc_cnt [NSRC];
    int  done_cnt = 0;
    int  hdr_cyc = 0;
    int  last_acc_cyc = 0;
    int  last_hs_cyc = 0;
    int  onehot_err = 0;
    bit  rand_ready = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source and sink driver: presents queue heads, sets downstream ready.
    initial begin
        in_tvalid  = '0;
        in_tdata   = '0;
        in_tlast   = '0;
        out_tready = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int s = 0; s < NSRC; s++) begin
                if (srcq[s].size() > 0) begin
                    in_tvalid[s]          = 1'b1;
                    in_tdata[s*DW +: DW]  = srcq[s][0].d;
                    in_tlast[s]           = srcq[s][0].l;
                end else begin
                    in_tvalid[s]          = 1'b0;
                    in_tdata[s*DW +: DW]  = '0;
                    in_tlast[s]           = 1'b0;
                end
            end
            out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: sampled mid-cycle, records input and output handshakes.
    initial begin : mon
        beat_t tmp;
        bit    prev_vld;
        prev_vld = 1'b0;
        for (int s = 0; s < NSRC; s++) acc_cnt[s] = 0;
        forever begin
            @(negedge clk);
            if ($countones(in_tready) > 1) onehot_err++;
            for (int s = 0; s < NSRC; s++) begin
                if (!rst && in_tvalid[s] && in_tready[s] && srcq[s].size() > 0) begin
                    acc_cnt[s]++;
                    if (srcq[s][0].l) last_acc_cyc = cyc;
                    tmp = srcq[s].pop_front();
                end
            end
            if (out_tvalid && !prev_vld) hdr_cyc = cyc;
            prev_vld = out_tvalid;
            if (!rst && out_tvalid && out_tready) begin
                obeats.push_back('{d: out_tdata, l: out_tlast});
                last_hs_cyc = cyc;
                if (out_tlast) done_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int s, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            srcq[s].push_back('{d: base + 64'(i), l: (i == n - 1)});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s timeout: packets done %0d expected %0d", name, done_cnt, target);
        end
    endtask

    function automatic logic [63:0] obeat_d(input int i);
        return (i < obeats.size()) ? obeats[i].d : 64'hx;
    endfunction

    vec_t vt[7];

    initial begin
        int          d0, a0, nout, bad, k, len, ntr;
        logic [63:0] w;
        bit          tr;

        rst = 1'b1;
        ena = 1'b1;

        vt[0] = '{src: 1, nw: 4,  base: 64'h11,   rnd: 0, hdr: 64'hF101_0000_0000_0004, pkts: 1, truncs: 0};
        vt[1] = '{src: 0, nw: 1,  base: 64'h100,  rnd: 0, hdr: 64'hF000_0000_0001_0001, pkts: 2, truncs: 0};
        vt[2] = '{src: 2, nw: 64, base: 64'h200,  rnd: 0, hdr: 64'hF202_0000_0002_0040, pkts: 3, truncs: 0};
        vt[3] = '{src: 0, nw: 70, base: 64'h300,  rnd: 0, hdr: 64'hF000_0001_0003_0040, pkts: 4, truncs: 1};
        vt[4] = '{src: 2, nw: 65, base: 64'h400,  rnd: 0, hdr: 64'hF202_0001_0004_0040, pkts: 5, truncs: 2};
        vt[5] = '{src: 1, nw: 10, base: 64'h500,  rnd: 1, hdr: 64'hF101_0000_0005_000A, pkts: 6, truncs: 2};
        vt[6] = '{src: 1, nw: 2,  base: 64'h600,  rnd: 0, hdr: 64'hF101_0000_0006_0002, pkts: 7, truncs: 2};

        // Reset state
        do_reset();
        check64("rst_out_tdata",   out_tdata, 64'h0);
        check64("rst_out_tvalid",  64'(out_tvalid), 64'h0);
        check64("rst_out_tlast",   64'(out_tlast), 64'h0);
        check64("rst_in_tready",   64'(in_tready), 64'h0);
        check64("rst_pkt_count",   64'(pkt_count), 64'h0);
        check64("rst_trunc_count", 64'(trunc_count), 64'h0);
        check64("rst_busy",        64'(busy), 64'h0);

        // Table-driven single-packet vectors
        for (int v = 0; v < 7; v++) begin
            obeats.delete();
            a0 = acc_cnt[vt[v].src];
            d0 = done_cnt;
            rand_ready = vt[v].rnd;
            push_pkt(vt[v].src, vt[v].nw, vt[v].base);
            wait_done(d0 + 1, 3000, $sformatf("vec%0d", v));
            rand_ready = 1'b0;
            nout = (vt[v].nw > MAXL) ? MAXL : vt[v].nw;
            check64($sformatf("vec%0d_header", v), obeat_d(0), vt[v].hdr);
            check64($sformatf("vec%0d_beats", v), 64'(obeats.size()), 64'(nout + 1));
            bad = 0;
            if (obeats.size() > 0 && obeats[0].l !== 1'b0) bad++;
            for (int i = 0; i < nout; i++) begin
                if (i + 1 < obeats.size()) begin
                    if (obeats[i+1].d !== vt[v].base + 64'(i) || obeats[i+1].l !== (i == nout - 1)) bad++;
                end
            end
            check64($sformatf("vec%0d_payload_errs", v), 64'(bad), 64'h0);
            check64($sformatf("vec%0d_pkt_count", v), 64'(pkt_count), 64'(vt[v].pkts));
            check64($sformatf("vec%0d_trunc_count", v), 64'(trunc_count), 64'(vt[v].truncs));
            check64($sformatf("vec%0d_accepted", v), 64'(acc_cnt[vt[v].src] - a0), 64'(vt[v].nw));
            if (!vt[v].rnd) begin
                check64($sformatf("vec%0d_hdr_latency", v), 64'(hdr_cyc - last_acc_cyc), 64'h1);
                check64($sformatf("vec%0d_drain_cycles", v), 64'(last_hs_cyc - hdr_cyc), 64'(nout));
            end
        end

        // ena dropped as FILL starts: packet completes, no further grant
        obeats.delete();
        d0 = done_cnt;
        ena = 1'b1;
        push_pkt(0, 8, 64'h800);
        k = 0;
        while (!busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        ena = 1'b0;
        check64("ena_fill_started", 64'(busy), 64'h1);
        push_pkt(1, 2, 64'h810);
        push_pkt(2, 2, 64'h820);
        wait_done(d0 + 1, 500, "ena_pkt");
        check64("ena_header", obeat_d(0), 64'hF000_0000_0007_0008);
        check64("ena_beats", 64'(obeats.size()), 64'd9);
        check64("ena_pkt_count", 64'(pkt_count), 64'd8);
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (busy || in_tready != '0) bad++;
        end
        check64("ena_hold_idle_cycles", 64'(bad), 64'h0);
        check64("ena_no_emit", 64'(obeats.size()), 64'd9);
        srcq[1].delete();
        srcq[2].delete();
        repeat (2) @(posedge clk);
        #1;
        ena = 1'b1;

        // Reset while the third payload word is on the output
        obeats.delete();
        push_pkt(1, 8, 64'h900);
        k = 0;
        while (obeats.size() < 3 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check64("rst_mid_reached_drain", 64'(obeats.size()), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check64("rstmid_out_tdata",   out_tdata, 64'h0);
        check64("rstmid_out_tvalid",  64'(out_tvalid), 64'h0);
        check64("rstmid_out_tlast",   64'(out_tlast), 64'h0);
        check64("rstmid_in_tready",   64'(in_tready), 64'h0);
        check64("rstmid_pkt_count",   64'(pkt_count), 64'h0);
        check64("rstmid_trunc_count", 64'(trunc_count), 64'h0);
        check64("rstmid_busy",        64'(busy), 64'h0);
        rst = 1'b0;
        obeats.delete();
        d0 = done_cnt;
        push_pkt(2, 3, 64'hA00);
        wait_done(d0 + 1, 500, "after_rst_pkt");
        check64("after_rst_header", obeat_d(0), 64'hF202_0000_0000_0003);
        check64("after_rst_beats", 64'(obeats.size()), 64'd4);
        check64("after_rst_pkt_count", 64'(pkt_count), 64'd1);

        // Randomized run: all sources stay backlogged, so packets must come
        // out strictly rotating 1,2,0,... with seq counting from zero.
        do_reset();
        obeats.delete();
        expq.delete();
        d0 = done_cnt;
        ntr = 0;
        for (int n = 0; n < 15; n++) begin
            int s;
            s    = (n + 1) % NSRC;
            len  = (n < 6) ? 2 : int'($urandom_range(1, 80));
            tr   = (len > MAXL);
            nout = tr ? MAXL : len;
            if (tr) ntr++;
            expq.push_back('{d: {8'(8'hF0 + s), 8'(s), 15'd0, tr, 16'(n), 16'(nout)}, l: 1'b0});
            for (int i = 0; i < len; i++) begin
                w = {$urandom, $urandom};
                srcq[s].push_back('{d: w, l: (i == len - 1)});
                if (i < nout) expq.push_back('{d: w, l: (i == nout - 1)});
            end
        end
        rand_ready = 1'b1;
        wait_done(d0 + 15, 30000, "rand_run");
        rand_ready = 1'b0;
        check64("rand_beats", 64'(obeats.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (i >= obeats.size()) begin
                errors++;
                $display("FAIL rand_beat%0d: missing, expected %h last=%0b", i, expq[i].d, expq[i].l);
            end else if (obeats[i].d !== expq[i].d || obeats[i].l !== expq[i].l) begin
                errors++;
                $display("FAIL rand_beat%0d: got %h last=%0b expected %h last=%0b",
                         i, obeats[i].d, obeats[i].l, expq[i].d, expq[i].l);
            end
        end
        check64("rand_pkt_count", 64'(pkt_count), 64'd15);
        check64("rand_trunc_count", 64'(trunc_count), 64'(ntr));
        check64("tready_onehot_violations", 64'(onehot_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
